// File: rtl/legup_mutex_bank.sv
// Bank of NUM_MUTEX recursive mutexes with optional lease auto-release behind one Avalon-MM slave.
// Writes commit at the clock edge (1-cycle latency); reads are combinational; waitrequest is never asserted.
module legup_mutex_bank #(
   parameter int NUM_MUTEX    = 4,
   parameter int ID_WIDTH     = 16,
   parameter int COUNT_WIDTH  = 4,
   parameter int LEASE_CYCLES = 0,
   parameter int ADDR_WIDTH   = $clog2(NUM_MUTEX) + 2
) (
   input  logic                  csi_clockreset_clk,
   input  logic                  csi_clockreset_reset_n,
   input  logic [ADDR_WIDTH-1:0] avs_s1_address,
   input  logic                  avs_s1_read,
   input  logic                  avs_s1_write,
   input  logic [31:0]           avs_s1_writedata,
   output logic [31:0]           avs_s1_readdata,
   output logic                  avs_s1_waitrequest
);

   localparam int LEASE_W = (LEASE_CYCLES > 0) ? $clog2(LEASE_CYCLES + 1) : 1;
   localparam logic [LEASE_W-1:0]     LEASE_RELOAD = LEASE_W'(LEASE_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = COUNT_WIDTH'(1);

   logic                   locked_q  [NUM_MUTEX];
   logic                   locked_d  [NUM_MUTEX];
   logic [ID_WIDTH-1:0]    owner_q   [NUM_MUTEX];
   logic [ID_WIDTH-1:0]    owner_d   [NUM_MUTEX];
   logic [COUNT_WIDTH-1:0] count_q   [NUM_MUTEX];
   logic [COUNT_WIDTH-1:0] count_d   [NUM_MUTEX];
   logic                   expired_q [NUM_MUTEX];
   logic                   expired_d [NUM_MUTEX];
   logic [LEASE_W-1:0]     lease_q   [NUM_MUTEX];
   logic [LEASE_W-1:0]     lease_d   [NUM_MUTEX];
   logic                   result_q;
   logic                   result_d;

   logic [31:0]          idx;
   logic [1:0]           offset;
   logic [ID_WIDTH-1:0]  req;
   logic                 in_range;
   logic                 owner_hit;
   logic                 unused_wdata;

   assign idx          = 32'(avs_s1_address >> 2);
   assign offset       = avs_s1_address[1:0];
   assign req          = avs_s1_writedata[ID_WIDTH-1:0];
   assign in_range     = (idx < 32'(NUM_MUTEX));
   assign unused_wdata = ^avs_s1_writedata[31:ID_WIDTH];

   assign avs_s1_waitrequest = 1'b0;

   always_comb begin
      result_d  = result_q;
      owner_hit = 1'b0;
      for (int i = 0; i < NUM_MUTEX; i++) begin
         locked_d[i]  = locked_q[i];
         owner_d[i]   = owner_q[i];
         count_d[i]   = count_q[i];
         expired_d[i] = expired_q[i];
         lease_d[i]   = lease_q[i];
         // Lease ticks first; a successful owner op or force below overrides it.
         if (LEASE_CYCLES > 0 && locked_q[i]) begin
            if (lease_q[i] == LEASE_W'(1)) begin
               locked_d[i]  = 1'b0;
               owner_d[i]   = '0;
               count_d[i]   = '0;
               expired_d[i] = 1'b1;
               lease_d[i]   = '0;
            end else begin
               lease_d[i] = lease_q[i] - LEASE_W'(1);
            end
         end
      end
      if (avs_s1_write) begin
         if (!in_range) begin
            result_d = 1'b0;
         end else begin
            for (int i = 0; i < NUM_MUTEX; i++) begin
               if (idx == 32'(i)) begin
                  owner_hit = locked_q[i] && (owner_q[i] == req);
                  case (offset)
                     2'd0: begin
                        if (!locked_q[i]) begin
                           locked_d[i]  = 1'b1;
                           owner_d[i]   = req;
                           count_d[i]   = COUNT_ONE;
                           expired_d[i] = 1'b0;
                           lease_d[i]   = LEASE_RELOAD;
                           result_d     = 1'b1;
                        end else if (owner_hit && count_q[i] != COUNT_MAX) begin
                           locked_d[i]  = 1'b1;
                           owner_d[i]   = owner_q[i];
                           count_d[i]   = count_q[i] + COUNT_ONE;
                           expired_d[i] = expired_q[i];
                           lease_d[i]   = LEASE_RELOAD;
                           result_d     = 1'b1;
                        end else begin
                           result_d = 1'b0;
                        end
                     end
                     2'd1: begin
                        if (owner_hit) begin
                           result_d     = 1'b1;
                           expired_d[i] = expired_q[i];
                           if (count_q[i] != COUNT_ONE) begin
                              locked_d[i] = 1'b1;
                              owner_d[i]  = owner_q[i];
                              count_d[i]  = count_q[i] - COUNT_ONE;
                              lease_d[i]  = LEASE_RELOAD;
                           end else begin
                              locked_d[i] = 1'b0;
                              owner_d[i]  = '0;
                              count_d[i]  = '0;
                              lease_d[i]  = '0;
                           end
                        end else begin
                           result_d = 1'b0;
                        end
                     end
                     2'd3: begin
                        result_d     = locked_q[i];
                        locked_d[i]  = 1'b0;
                        owner_d[i]   = '0;
                        count_d[i]   = '0;
                        expired_d[i] = 1'b0;
                        lease_d[i]   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   always_comb begin
      avs_s1_readdata = '0;
      if (avs_s1_read && in_range) begin
         for (int i = 0; i < NUM_MUTEX; i++) begin
            if (idx == 32'(i)) begin
               case (offset)
                  2'd0:    avs_s1_readdata = {31'b0, result_q};
                  2'd1:    avs_s1_readdata = 32'(owner_q[i]);
                  2'd2:    avs_s1_readdata = {locked_q[i], expired_q[i], 6'(count_q[i]), 24'(owner_q[i])};
                  default: avs_s1_readdata = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge csi_clockreset_clk) begin
      if (!csi_clockreset_reset_n) begin
         result_q <= 1'b0;
         for (int i = 0; i < NUM_MUTEX; i++) begin
            locked_q[i]  <= 1'b0;
            owner_q[i]   <= '0;
            count_q[i]   <= '0;
            expired_q[i] <= 1'b0;
            lease_q[i]   <= '0;
         end
      end else begin
         result_q <= result_d;
         for (int i = 0; i < NUM_MUTEX; i++) begin
            locked_q[i]  <= locked_d[i];
            owner_q[i]   <= owner_d[i];
            count_q[i]   <= count_d[i];
            expired_q[i] <= expired_d[i];
            lease_q[i]   <= lease_d[i];
         end
      end
   end

endmodule

// File: tb/tb_legup_mutex_bank.sv
// Bench for legup_mutex_bank: a leased 3-lock instance checked against a behavioural model,
// plus a default-parameter instance for lease-free recursion depth.
module tb_legup_mutex_bank;

   localparam int NM    = 3;
   localparam int IDW   = 16;
   localparam int CW    = 2;
   localparam int LEASE = 10;
   localparam int AW    = $clog2(NM) + 2;
   localparam int MAXC  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] a_addr;
   logic          a_rd, a_wr;
   logic [31:0]   a_wdata;
   logic [31:0]   a_rdata;
   logic          a_wait;

   logic [3:0]    b_addr;
   logic          b_rd, b_wr;
   logic [31:0]   b_wdata;
   logic [31:0]   b_rdata;
   logic          b_wait;

   logic [31:0]   last_rd, b_last;
   int checks = 0;
   int errors = 0;

   int m_locked [NM];
   int m_owner  [NM];
   int m_count  [NM];
   int m_expired[NM];
   int m_lease  [NM];
   int m_result;

   always #5 clk = ~clk;

   legup_mutex_bank #(
      .NUM_MUTEX(NM), .ID_WIDTH(IDW), .COUNT_WIDTH(CW), .LEASE_CYCLES(LEASE)
   ) dut_a (
      .csi_clockreset_clk     (clk),
      .csi_clockreset_reset_n (rst_n),
      .avs_s1_address         (a_addr),
      .avs_s1_read            (a_rd),
      .avs_s1_write           (a_wr),
      .avs_s1_writedata       (a_wdata),
      .avs_s1_readdata        (a_rdata),
      .avs_s1_waitrequest     (a_wait)
   );

   legup_mutex_bank dut_b (
      .csi_clockreset_clk     (clk),
      .csi_clockreset_reset_n (rst_n),
      .avs_s1_address         (b_addr),
      .avs_s1_read            (b_rd),
      .avs_s1_write           (b_wr),
      .avs_s1_writedata       (b_wdata),
      .avs_s1_readdata        (b_rdata),
      .avs_s1_waitrequest     (b_wait)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NM; i++) begin
         m_locked[i] = 0; m_owner[i] = 0; m_count[i] = 0; m_expired[i] = 0; m_lease[i] = 0;
      end
      m_result = 0;
   endtask

   function automatic logic [31:0] model_read(input int idx, input int off);
      logic [31:0] v;
      v = 32'h0;
      if (idx < NM) begin
         case (off)
            0: v = 32'(m_result);
            1: v = 32'(m_owner[idx]);
            2: v = 32'(m_owner[idx]) + 32'(m_count[idx]) * 32'h0100_0000
                 + 32'(m_expired[idx]) * 32'h4000_0000 + 32'(m_locked[idx]) * 32'h8000_0000;
            default: v = 32'h0;
         endcase
      end
      return v;
   endfunction

   // One clock edge of the bank, stated as the lock rules: leases age on every
   // held lock, then the addressed operation decides from the pre-edge state.
   task automatic model_edge(input bit wr, input int idx, input int off, input int id);
      int nl[NM], no[NM], nc[NM], ne[NM], ns[NM];
      for (int i = 0; i < NM; i++) begin
         nl[i] = m_locked[i]; no[i] = m_owner[i]; nc[i] = m_count[i];
         ne[i] = m_expired[i]; ns[i] = m_lease[i];
         if (m_locked[i] != 0) begin
            if (m_lease[i] == 1) begin
               nl[i] = 0; no[i] = 0; nc[i] = 0; ne[i] = 1; ns[i] = 0;
            end else begin
               ns[i] = m_lease[i] - 1;
            end
         end
      end
      if (wr) begin
         if (idx >= NM) begin
            m_result = 0;
         end else if (off == 0) begin
            if (m_locked[idx] == 0) begin
               nl[idx] = 1; no[idx] = id; nc[idx] = 1; ne[idx] = 0; ns[idx] = LEASE;
               m_result = 1;
            end else if (m_owner[idx] == id && m_count[idx] < MAXC) begin
               nl[idx] = 1; no[idx] = id; nc[idx] = m_count[idx] + 1;
               ne[idx] = m_expired[idx]; ns[idx] = LEASE;
               m_result = 1;
            end else begin
               m_result = 0;
            end
         end else if (off == 1) begin
            if (m_locked[idx] != 0 && m_owner[idx] == id) begin
               m_result = 1;
               ne[idx] = m_expired[idx];
               if (m_count[idx] > 1) begin
                  nl[idx] = 1; no[idx] = id; nc[idx] = m_count[idx] - 1; ns[idx] = LEASE;
               end else begin
                  nl[idx] = 0; no[idx] = 0; nc[idx] = 0; ns[idx] = 0;
               end
            end else begin
               m_result = 0;
            end
         end else if (off == 3) begin
            m_result = (m_locked[idx] != 0) ? 1 : 0;
            nl[idx] = 0; no[idx] = 0; nc[idx] = 0; ne[idx] = 0; ns[idx] = 0;
         end
      end
      for (int i = 0; i < NM; i++) begin
         m_locked[i] = nl[i]; m_owner[i] = no[i]; m_count[i] = nc[i];
         m_expired[i] = ne[i]; m_lease[i] = ns[i];
      end
   endtask

   // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic cycle(input bit wr, input int idx, input int off, input int id);
      a_wr    = wr;
      a_addr  = AW'(idx * 4 + off);
      a_wdata = $urandom;
      a_wdata[IDW-1:0] = IDW'(id);
      @(negedge clk);
      last_rd = a_rdata;
      b_last  = b_rdata;
      check($sformatf("readdata idx%0d off%0d", idx, off), last_rd, model_read(idx, off));
      check("waitrequest", 32'(a_wait), 32'h0);
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge(wr, idx, off, id);
      #1;
      a_wr = 1'b0;
   endtask

   task automatic rd(input int idx, input int off);
      cycle(1'b0, idx, off, 0);
   endtask

   task automatic wr(input int idx, input int off, input int id);
      cycle(1'b1, idx, off, id);
   endtask

   task automatic b_step(input bit w, input int idx, input int off, input int id);
      b_wr    = w;
      b_addr  = 4'(idx * 4 + off);
      b_wdata = 32'(id);
      cycle(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      b_wr    = 1'b0;
   endtask

   initial begin
      int ids[3];
      ids[0] = 'h12; ids[1] = 'h34; ids[2] = 'h56;
      rst_n = 1'b0; a_rd = 1'b1; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
      b_rd = 1'b1; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
      model_reset();
      @(posedge clk);
      #1;
      rd(0, 2);
      rd(1, 0);
      rst_n = 1'b1;

      for (int i = 0; i <= NM; i++) begin
         rd(i, 2);
         check("reset status", last_rd, 32'h0);
      end

      // Basic acquire and contention
      wr(0, 0, 'h12);
      rd(0, 0);  check("trylock free result", last_rd, 32'h1);
      rd(0, 2);  check("trylock status", last_rd, 32'h8100_0012);
      wr(0, 0, 'h34);
      rd(0, 0);  check("trylock other result", last_rd, 32'h0);
      rd(0, 1);  check("owner kept", last_rd, 32'h12);
      wr(0, 1, 'h34);
      rd(0, 0);  check("unlock other result", last_rd, 32'h0);
      rd(0, 2);  check("status after foreign ops", last_rd, 32'h8100_0012);
      wr(0, 1, 'h12);

      // Recursion up to saturation and back down
      for (int k = 0; k < 4; k++) begin
         wr(0, 0, 'h12);
         rd(0, 0);
         check($sformatf("recursive trylock %0d", k), last_rd, (k < 3) ? 32'h1 : 32'h0);
      end
      rd(0, 2);  check("saturated status", last_rd, 32'h8300_0012);
      for (int k = 0; k < 3; k++) begin
         wr(0, 1, 'h12);
         rd(0, 0);
         check($sformatf("recursive unlock %0d", k), last_rd, 32'h1);
      end
      rd(0, 2);  check("free after unlocks", last_rd, 32'h0);
      wr(0, 1, 'h12);
      rd(0, 0);  check("unlock free result", last_rd, 32'h0);

      // Lease expiry when idle
      wr(1, 0, 'h56);
      repeat (10) rd(1, 2);
      check("held just before expiry", last_rd, 32'h8100_0056);
      rd(1, 2);  check("expired status", last_rd, 32'h4000_0000);
      wr(1, 0, 'h34);
      rd(1, 0);  check("trylock after expiry", last_rd, 32'h1);
      rd(1, 2);  check("expired cleared", last_rd, 32'h8100_0034);
      repeat (7) rd(1, 2);
      wr(1, 0, 'h34);
      rd(1, 2);  check("owner op on expiry edge", last_rd, 32'h8200_0034);
      repeat (8) rd(1, 2);
      check("held after reload", last_rd, 32'h8200_0034);
      wr(1, 0, 'h99);
      rd(1, 0);  check("foreign trylock on expiry edge", last_rd, 32'h0);
      rd(1, 2);  check("expired after foreign trylock", last_rd, 32'h4000_0000);

      // Force release
      wr(2, 0, 'h77);
      wr(2, 3, 'h0);
      rd(2, 0);  check("force held result", last_rd, 32'h1);
      rd(2, 2);  check("force status", last_rd, 32'h0);
      wr(2, 3, 'h0);
      rd(2, 0);  check("force free result", last_rd, 32'h0);

      // Out-of-range index
      wr(0, 0, 'h12);
      rd(0, 0);  check("trylock before oob", last_rd, 32'h1);
      wr(3, 0, 'h12);
      rd(0, 0);  check("oob write result", last_rd, 32'h0);
      for (int off = 0; off < 4; off++) begin
         rd(3, off);
         check($sformatf("oob read off%0d", off), last_rd, 32'h0);
      end
      rd(0, 2);  check("idx0 unaffected by oob", last_rd, 32'h8100_0012);

      // Randomised traffic against the model, with idle gaps so leases expire
      repeat (800) begin
         int idx, off, id;
         bit w;
         idx = int'($urandom_range(0, 3));
         off = int'($urandom_range(0, 3));
         id  = ids[$urandom_range(0, 2)];
         w   = ($urandom_range(0, 2) == 0);
         cycle(w, idx, off, id);
      end

      // Reset beats a write in the same cycle
      wr(0, 0, 'h56);
      wr(2, 0, 'h56);
      rst_n = 1'b0;
      wr(1, 0, 'h34);
      rst_n = 1'b1;
      for (int i = 0; i < NM; i++) begin
         rd(i, 2);
         check($sformatf("mid reset status %0d", i), last_rd, 32'h0);
      end
      rd(0, 0);  check("mid reset result", last_rd, 32'h0);

      // Default instance: no lease, 4-bit recursion
      b_step(1'b0, 3, 2, 0);
      check("b reset status", b_last, 32'h0);
      b_step(1'b1, 3, 0, 'hABCD);
      b_step(1'b0, 3, 2, 0);
      check("b trylock status", b_last, 32'h8100_ABCD);
      repeat (40) b_step(1'b0, 3, 2, 0);
      check("b no lease expiry", b_last, 32'h8100_ABCD);
      repeat (14) b_step(1'b1, 3, 0, 'hABCD);
      b_step(1'b0, 3, 0, 0);
      check("b depth 15 result", b_last, 32'h1);
      b_step(1'b0, 3, 2, 0);
      check("b depth 15 status", b_last, 32'h8F00_ABCD);
      b_step(1'b1, 3, 0, 'hABCD);
      b_step(1'b0, 3, 0, 0);
      check("b saturated result", b_last, 32'h0);
      b_step(1'b1, 3, 1, 'h1234);
      b_step(1'b0, 3, 2, 0);
      check("b foreign unlock status", b_last, 32'h8F00_ABCD);
      b_step(1'b0, 2, 2, 0);
      check("b other lock free", b_last, 32'h0);
      check("b waitrequest", 32'(b_wait), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/legup_mutex_bank.md
# legup_mutex_bank

- Bank of `NUM_MUTEX` independent hardware mutexes behind one Avalon-MM slave.
- Used by the processor and LegUp accelerators to serialise access to shared resources.
- Extends the single-lock mutex with:
  - per-lock recursive ownership counts;
  - an optional lease timer that auto-releases locks held too long;
  - an administrative force-release;
  - a readable result of the last operation.
- Reads are combinational and zero-wait; write operations commit on the clock edge.

## Interface

Parameters:
- `NUM_MUTEX`, 4 — number of locks; ≥1.
- `ID_WIDTH`, 16 — owner ID width; 1..24.
- `COUNT_WIDTH`, 4 — recursion counter width; 1..6; max depth 2^COUNT_WIDTH−1.
- `LEASE_CYCLES`, 0 — cycles without owner activity before auto-release; 0 disables leasing.
- `ADDR_WIDTH`, clog2(NUM_MUTEX)+2 — derived; not to be overridden.

Ports:
- `csi_clockreset_clk`  in  1  — sole clock.
- `csi_clockreset_reset_n`  in  1  — synchronous, active-low reset.
- `avs_s1_address`  in  ADDR_WIDTH  — [ADDR_WIDTH−1:2] mutex index; [1:0] register offset.
- `avs_s1_read`  in  1  — read strobe.
- `avs_s1_write`  in  1  — write strobe.
- `avs_s1_writedata`  in  32  — [ID_WIDTH−1:0] requester ID; upper bits ignored.
- `avs_s1_readdata`  out  32  — combinational read data.
- `avs_s1_waitrequest`  out  1  — tied 0.

## Operation

Per-mutex state: `locked`, `owner[ID_WIDTH]`, `count[COUNT_WIDTH]`, `expired`, `lease` counter. Global state: `result` (1 bit).

Write offsets (req = writedata ID):
- **0 TRYLOCK**
  - Free: lock; owner=req; count=1; expired=0; result=1.
  - Held by req with count<max: count+1; result=1.
  - Held by req at max count, or held by another ID: no change; result=0.
- **1 UNLOCK**
  - Held by req, count>1: count−1; result=1.
  - Held by req, count==1: free; owner=0; count=0; result=1.
  - Free, or held by another ID: no change; result=0.
- **3 FORCE_RELEASE**
  - Free; owner=0; count=0; expired=0 regardless of req.
  - result=1 if the lock was held, else 0.
- **Offset 2:** writes ignored; result unchanged.
- **Out-of-range index** (≥NUM_MUTEX): writes ignored; result=0. Reads return 0.

Read offsets:
- **0:** {31'b0, result}.
- **1:** owner, zero-extended.
- **2 STATUS:** bit31 locked; bit30 expired; [29:24] count, zero-extended; [23:0] owner, zero-extended.
- **3:** 0.
- Reads have no side effects. Simultaneous read and write: read returns pre-edge state.

Lease (LEASE_CYCLES>0 only):
- Reload `lease`=LEASE_CYCLES on every successful TRYLOCK or UNLOCK by the owner that leaves the lock held.
- Decrement `lease` each cycle while held.
- On a cycle where lease==1 and no successful owner operation targets that mutex, at the edge:
  - free the mutex (owner=0, count=0);
  - set expired=1. Sticky until the next successful TRYLOCK or FORCE_RELEASE.
- With LEASE_CYCLES=0, lease logic is absent and expired stays 0.

## Timing

- **Reset** (reset_n low at an edge): all locked/owner/count/expired/lease=0; result=0. Consequently readdata=0 for every address, and waitrequest=0 always.
- **Reset mid-operation:** reset wins over any write in the same cycle.
- **Commit:** a write takes effect at the edge where write=1. Readback of the new state is valid the following cycle. Latency is 1 cycle; the master never stalls.
- **Simultaneous lease expiry and owner operation** on the same mutex: the owner operation wins; lease reloads, or the mutex frees via UNLOCK. In the free case expired stays 0.
- **Simultaneous expiry and non-owner TRYLOCK:** TRYLOCK fails (result=0); the mutex is free next cycle with expired=1.
- **Simultaneous expiry and FORCE_RELEASE:** force wins; expired=0.
- **Other mutexes** are unaffected by operations on one; their lease timers run concurrently.
- **Count wrap:** counts never wrap; saturation is reported as failure.

## Test plan

1. Reset, then read STATUS of every index → 0. Write TRYLOCK idx0 ID 0x12 → result=1; STATUS=0x8100_0012.
2. TRYLOCK idx0 ID 0x34 while held by 0x12 → result=0; owner stays 0x12. UNLOCK by 0x34 → result=0, no change.
3. COUNT_WIDTH=2: TRYLOCK 0x12 four times → results 1,1,1,0; count=3. UNLOCK three times → results 1,1,1; lock free. Fourth UNLOCK → result=0.
4. LEASE_CYCLES=10:
   - Acquire idx1, then idle → exactly 10 cycles later STATUS bit31=0, bit30=1.
   - Then TRYLOCK by 0x34 succeeds and clears bit30.
   - Repeat with an owner TRYLOCK on the expiry cycle → lock stays held and lease reloads.
5. FORCE_RELEASE on held idx2 → result=1, free. FORCE_RELEASE on free idx2 → result=0.
6. NUM_MUTEX=3: write TRYLOCK to idx3 → result=0; reads of idx3 = 0. Operations on idx0..2 are unaffected; a mid-sequence reset clears everything.
